// File: rtl/sync_ram_sdp.sv
// Simple-dual-port synchronous RAM with hardware clear sweep and per-word written flags.
// Define RAM_BYPASS_EN for write-first same-address collisions (read-first otherwise).
module sync_ram_sdp #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk_2,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  clr_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_hit,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        S_SWEEP,
        S_IDLE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_written;

    logic                  w_idle;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_flag;

    assign w_idle      = (r_state == S_IDLE);
    // The sweep and the user write share the single RAM write port.
    assign w_mem_we    = rst_n & (~w_idle | wr_en);
    assign w_mem_addr  = w_idle ? wr_addr : r_ptr[ADDR_WIDTH-1:0];
    assign w_mem_wdata = w_idle ? wr_data : '0;

`ifdef RAM_BYPASS_EN
    logic w_collide;
    assign w_collide = wr_en & (wr_addr == rd_addr);
    assign w_rd_word = w_collide ? wr_data : r_mem[rd_addr];
    assign w_rd_flag = w_collide | r_written[rd_addr];
`else
    assign w_rd_word = r_mem[rd_addr];
    assign w_rd_flag = r_written[rd_addr];
`endif

    always_ff @(posedge clk_2) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr]     <= w_mem_wdata;
            r_written[w_mem_addr] <= w_idle;
        end
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_state  <= S_SWEEP;
            r_ptr    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            busy     <= 1'b1;
        end else begin
            unique case (r_state)
                S_SWEEP: begin
                    rd_valid <= 1'b0;
                    r_ptr    <= r_ptr + 1'b1;
                    if (r_ptr == LAST_PTR) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_IDLE: begin
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        rd_data <= w_rd_word;
                        rd_hit  <= w_rd_flag;
                    end
                    if (clr_req) begin
                        r_state <= S_SWEEP;
                        r_ptr   <= '0;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_ram_sdp.sv
// Directed table-driven bench for sync_ram_sdp (2x4 default and 4x8 instances).
// Collision expectations follow RAM_BYPASS_EN.
module tb_sync_ram_sdp;

    logic       clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    logic       s_rst_n, s_wr_en, s_rd_en, s_clr;
    logic [1:0] s_wa, s_ra;
    logic [3:0] s_wd, s_rdata;
    logic       s_valid, s_hit, s_busy;

    logic       b_rst_n, b_wr_en, b_rd_en, b_clr;
    logic [3:0] b_wa, b_ra;
    logic [7:0] b_wd, b_rdata;
    logic       b_valid, b_hit, b_busy;

    sync_ram_sdp #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) u_small (
        .clk_2(clk_2), .rst_n(s_rst_n), .wr_en(s_wr_en), .wr_addr(s_wa),
        .wr_data(s_wd), .rd_en(s_rd_en), .rd_addr(s_ra), .clr_req(s_clr),
        .rd_data(s_rdata), .rd_valid(s_valid), .rd_hit(s_hit), .busy(s_busy)
    );

    sync_ram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u_big (
        .clk_2(clk_2), .rst_n(b_rst_n), .wr_en(b_wr_en), .wr_addr(b_wa),
        .wr_data(b_wd), .rd_en(b_rd_en), .rd_addr(b_ra), .clr_req(b_clr),
        .rd_data(b_rdata), .rd_valid(b_valid), .rd_hit(b_hit), .busy(b_busy)
    );

`ifdef RAM_BYPASS_EN
    localparam logic [3:0] COL_A1 = 4'h7;
    localparam logic [3:0] COL_A0 = 4'h5;
    localparam logic       COL_H0 = 1'b1;
`else
    localparam logic [3:0] COL_A1 = 4'h3;
    localparam logic [3:0] COL_A0 = 4'h0;
    localparam logic       COL_H0 = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [3:0] wd;
        logic       re;
        logic [1:0] ra;
        logic       clr;
        logic       ev;
        logic [3:0] ed;
        logic       eh;
        logic       eb;
    } vec_t;

    vec_t tv[24];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic we, logic [1:0] wa, logic [3:0] wd,
                                logic re, logic [1:0] ra, logic clr,
                                logic ev, logic [3:0] ed, logic eh, logic eb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.clr = clr;
        v.ev = ev; v.ed = ed; v.eh = eh; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic s_idle_in();
        s_wr_en = 0; s_rd_en = 0; s_clr = 0; s_wa = 0; s_ra = 0; s_wd = 0;
    endtask

    // Counts edges after release until busy falls on both instances.
    task automatic sweep_len(output int sc, output int bc);
        sc = 0; bc = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (!s_busy && sc == 0) sc = i;
            if (!b_busy && bc == 0) bc = i;
            if (sc != 0 && bc != 0) break;
        end
    endtask

    task automatic s_read(input logic [1:0] a, input logic [3:0] ed, input logic eh, input string nm);
        s_rd_en = 1; s_ra = a;
        tick();
        s_rd_en = 0;
        chk({nm, "_valid"}, 32'(s_valid), 32'(1'b1));
        chk({nm, "_data"}, 32'(s_rdata), 32'(ed));
        chk({nm, "_hit"}, 32'(s_hit), 32'(eh));
    endtask

    initial begin
        int sc, bc;
        s_idle_in();
        b_wr_en = 0; b_rd_en = 0; b_clr = 0; b_wa = 0; b_ra = 0; b_wd = 0;
        s_rst_n = 0; b_rst_n = 0;

        tv[0]  = mk(0, 0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 0);
        tv[1]  = mk(0, 0, 4'h0, 1, 1, 0, 1, 4'h0, 0, 0);
        tv[2]  = mk(0, 0, 4'h0, 1, 2, 0, 1, 4'h0, 0, 0);
        tv[3]  = mk(0, 0, 4'h0, 1, 3, 0, 1, 4'h0, 0, 0);
        tv[4]  = mk(1, 2, 4'hA, 0, 0, 0, 0, 4'h0, 0, 0);
        tv[5]  = mk(0, 0, 4'h0, 1, 2, 0, 1, 4'hA, 1, 0);
        tv[6]  = mk(1, 1, 4'h3, 0, 0, 0, 0, 4'hA, 1, 0);
        tv[7]  = mk(1, 1, 4'h7, 1, 1, 0, 1, COL_A1, 1, 0);
        tv[8]  = mk(1, 0, 4'h5, 1, 0, 0, 1, COL_A0, COL_H0, 0);
        tv[9]  = mk(0, 0, 4'h0, 1, 1, 0, 1, 4'h7, 1, 0);
        tv[10] = mk(0, 0, 4'h0, 1, 0, 0, 1, 4'h5, 1, 0);
        tv[11] = mk(1, 3, 4'hC, 1, 2, 0, 1, 4'hA, 1, 0);
        tv[12] = mk(0, 0, 4'h0, 1, 3, 0, 1, 4'hC, 1, 0);
        tv[13] = mk(0, 0, 4'h0, 0, 0, 0, 0, 4'hC, 1, 0);
        tv[14] = mk(0, 0, 4'h0, 0, 0, 0, 0, 4'hC, 1, 0);
        tv[15] = mk(0, 0, 4'h0, 1, 2, 1, 1, 4'hA, 1, 1);
        tv[16] = mk(1, 0, 4'hF, 1, 0, 1, 0, 4'hA, 1, 1);
        tv[17] = mk(1, 0, 4'hF, 1, 0, 0, 0, 4'hA, 1, 1);
        tv[18] = mk(1, 0, 4'hF, 1, 0, 0, 0, 4'hA, 1, 1);
        tv[19] = mk(1, 0, 4'hF, 1, 0, 0, 0, 4'hA, 1, 0);
        tv[20] = mk(0, 0, 4'h0, 1, 0, 0, 1, 4'h0, 0, 0);
        tv[21] = mk(0, 0, 4'h0, 1, 1, 0, 1, 4'h0, 0, 0);
        tv[22] = mk(0, 0, 4'h0, 1, 2, 0, 1, 4'h0, 0, 0);
        tv[23] = mk(0, 0, 4'h0, 1, 3, 0, 1, 4'h0, 0, 0);

        tick();
        tick();
        chk("rst_busy", 32'(s_busy), 32'(1'b1));
        chk("rst_valid", 32'(s_valid), 32'(1'b0));
        chk("rst_data", 32'(s_rdata), 32'(4'h0));
        chk("rst_hit", 32'(s_hit), 32'(1'b0));
        chk("big_rst_busy", 32'(b_busy), 32'(1'b1));
        s_rst_n = 1; b_rst_n = 1;
        sweep_len(sc, bc);
        chk("sweep_len_small", 32'(sc), 32'd4);
        chk("sweep_len_big", 32'(bc), 32'd16);

        b_wr_en = 1; b_wa = 4'd9; b_wd = 8'hA5;
        tick();
        b_wr_en = 0; b_rd_en = 1; b_ra = 4'd9;
        tick();
        chk("big_rd9_valid", 32'(b_valid), 32'(1'b1));
        chk("big_rd9_data", 32'(b_rdata), 32'(8'hA5));
        chk("big_rd9_hit", 32'(b_hit), 32'(1'b1));
        b_ra = 4'd15;
        tick();
        b_rd_en = 0;
        chk("big_rd15_data", 32'(b_rdata), 32'(8'h00));
        chk("big_rd15_hit", 32'(b_hit), 32'(1'b0));

        for (int i = 0; i < 24; i++) begin
            s_wr_en = tv[i].we; s_wa = tv[i].wa; s_wd = tv[i].wd;
            s_rd_en = tv[i].re; s_ra = tv[i].ra; s_clr = tv[i].clr;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(s_valid), 32'(tv[i].ev));
            chk($sformatf("v%0d_data", i), 32'(s_rdata), 32'(tv[i].ed));
            chk($sformatf("v%0d_hit", i), 32'(s_hit), 32'(tv[i].eh));
            chk($sformatf("v%0d_busy", i), 32'(s_busy), 32'(tv[i].eb));
        end
        s_idle_in();

        // Reset in the middle of a clear sweep (pointer at 2).
        s_wr_en = 1; s_wa = 2; s_wd = 4'h6;
        tick();
        s_wr_en = 1; s_wa = 1; s_wd = 4'h9;
        s_rd_en = 1; s_ra = 2; s_clr = 1;
        tick();
        s_idle_in();
        chk("clr_acc_valid", 32'(s_valid), 32'(1'b1));
        chk("clr_acc_data", 32'(s_rdata), 32'(4'h6));
        chk("clr_busy", 32'(s_busy), 32'(1'b1));
        tick();
        tick();
        s_rst_n = 0;
        tick();
        chk("midrst_busy", 32'(s_busy), 32'(1'b1));
        chk("midrst_data", 32'(s_rdata), 32'(4'h0));
        chk("midrst_hit", 32'(s_hit), 32'(1'b0));
        s_rst_n = 1;
        sweep_len(sc, bc);
        chk("midrst_sweep_len", 32'(sc), 32'd4);
        s_read(1, 4'h0, 1'b0, "post_a1");
        s_read(2, 4'h0, 1'b0, "post_a2");
        tick();
        chk("post_idle_valid", 32'(s_valid), 32'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
